// File: rtl/vp_bin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vp_bin_pkg
// Description : Shared types and constants for the binarization LUT loader.
// Revision    : 1.0 - initial release
// ============================================================================
package vp_bin_pkg;

    // LUT geometry: one entry per 8-bit pixel code
    localparam int LUT_DEPTH = 256;
    localparam int ADDR_W    = 8;

    // Binarized output codes written into the LUTs
    localparam logic [7:0] BIN_ON  = 8'hFF;
    localparam logic [7:0] BIN_OFF = 8'h00;

    // Loader sequencing states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_PEND = 3'd1,
        WAIT_VS   = 3'd2,
        WRITE     = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vp_bin_band_cmp.sv
`default_nettype none
// ============================================================================
// Module      : vp_bin_band_cmp
// Description : Combinational pass-band test for one LUT entry. Produces
//               BIN_ON when lo <= addr <= hi (unsigned, inclusive), else
//               BIN_OFF; a set inv swaps the two codes.
// Revision    : 1.0 - initial release
// ============================================================================
module vp_bin_band_cmp
    import vp_bin_pkg::*;
(
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    input  logic [ADDR_W-1:0] addr,
    input  logic              inv,
    output logic [7:0]        entry
);

    logic w_in_band;

    // Inclusive band test; lo > hi naturally yields an empty band
    always_comb begin
        w_in_band = (addr >= lo) && (addr <= hi);
        entry     = (w_in_band ^ inv) ? BIN_ON : BIN_OFF;
    end

endmodule
`default_nettype wire

// File: rtl/vp_bin_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : vp_bin_lut_loader
// Description : Run-time loader for the R/G/B 256x8 binarization LUTs.
//               Accepts a pass band per channel, waits for the next vsync
//               edge, then rewrites all 256 entries of each LUT in 256
//               consecutive cycles and pulses done.
//               Optional feature macro: VP_BIN_INVERT_EN adds cfg_inv[2:0]
//               (bit0=R, bit1=G, bit2=B) to invert a channel's written data.
// Revision    : 1.0 - initial release
// ============================================================================
module vp_bin_lut_loader
    import vp_bin_pkg::*;
#(
    parameter logic       VSYNC_POL = 1'b1,
    parameter bit         INIT_LOAD = 1'b1,
    parameter logic [7:0] DEF_LO    = 8'd128,
    parameter logic [7:0] DEF_HI    = 8'd255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              v_sync_in,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [7:0]        cfg_lo_r,
    input  logic [7:0]        cfg_lo_g,
    input  logic [7:0]        cfg_lo_b,
    input  logic [7:0]        cfg_hi_r,
    input  logic [7:0]        cfg_hi_g,
    input  logic [7:0]        cfg_hi_b,
`ifdef VP_BIN_INVERT_EN
    input  logic [2:0]        cfg_inv,
`endif
    output logic              lut_we,
    output logic [ADDR_W-1:0] lut_addr,
    output logic [7:0]        lut_d_r,
    output logic [7:0]        lut_d_g,
    output logic [7:0]        lut_d_b,
    output logic              busy,
    output logic              done
);

    localparam state_t              RST_STATE = INIT_LOAD ? LOAD_PEND : IDLE;
    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(LUT_DEPTH - 1);

    state_t              r_state;
    state_t              w_next;
    logic                w_latch_cfg;
    logic                w_latch_def;
    logic                w_vs_edge;
    logic                r_vs_q;
    logic [ADDR_W-1:0]   r_cnt;
    logic [7:0]          r_lo [3];
    logic [7:0]          r_hi [3];
    logic [2:0]          r_inv;
    logic [2:0]          w_cfg_inv;
    logic [7:0]          w_entry [3];
    logic                r_lut_we;
    logic [ADDR_W-1:0]   r_lut_addr;
    logic [7:0]          r_lut_d [3];
    logic                r_done;

`ifdef VP_BIN_INVERT_EN
    assign w_cfg_inv = cfg_inv;
`else
    assign w_cfg_inv = 3'b000;
`endif

    // Handshake and status are pure state decodes
    assign cfg_ready = (r_state == IDLE);
    assign busy      = (r_state == WAIT_VS) || (r_state == WRITE);

    // Only an inactive->active transition starts a load, never a level
    assign w_vs_edge = (v_sync_in == VSYNC_POL) && (r_vs_q != VSYNC_POL);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and latch strobes
    always_comb begin
        w_next      = r_state;
        w_latch_cfg = 1'b0;
        w_latch_def = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_valid) begin
                    w_latch_cfg = 1'b1;
                    w_next      = WAIT_VS;
                end
            end
            LOAD_PEND: begin
                w_latch_def = 1'b1;
                w_next      = WAIT_VS;
            end
            WAIT_VS: begin
                if (w_vs_edge) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                if (r_cnt == LAST_ADDR) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Vsync history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_q <= 1'b0;
        end else begin
            r_vs_q <= v_sync_in;
        end
    end

    // Address counter: runs only while writing, parked at 0 otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == WRITE) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Band registers: user set on handshake, defaults for the post-reset load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_lo[i] <= DEF_LO;
                r_hi[i] <= DEF_HI;
            end
            r_inv <= 3'b000;
        end else if (w_latch_cfg) begin
            r_lo[0] <= cfg_lo_r;
            r_lo[1] <= cfg_lo_g;
            r_lo[2] <= cfg_lo_b;
            r_hi[0] <= cfg_hi_r;
            r_hi[1] <= cfg_hi_g;
            r_hi[2] <= cfg_hi_b;
            r_inv   <= w_cfg_inv;
        end else if (w_latch_def) begin
            for (int i = 0; i < 3; i++) begin
                r_lo[i] <= DEF_LO;
                r_hi[i] <= DEF_HI;
            end
            r_inv <= 3'b000;
        end
    end

    generate
        for (genvar g = 0; g < 3; g++) begin : g_band
            vp_bin_band_cmp u_cmp (
                .lo    (r_lo[g]),
                .hi    (r_hi[g]),
                .addr  (r_cnt),
                .inv   (r_inv[g]),
                .entry (w_entry[g])
            );
        end
    endgenerate

    // Registered write port: follows the state one cycle behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lut_we   <= 1'b0;
            r_lut_addr <= '0;
            for (int i = 0; i < 3; i++) begin
                r_lut_d[i] <= BIN_OFF;
            end
            r_done <= 1'b0;
        end else begin
            r_lut_we <= (r_state == WRITE);
            r_done   <= (r_state == DONE);
            if (r_state == WRITE) begin
                r_lut_addr <= r_cnt;
                for (int i = 0; i < 3; i++) begin
                    r_lut_d[i] <= w_entry[i];
                end
            end
        end
    end

    assign lut_we   = r_lut_we;
    assign lut_addr = r_lut_addr;
    assign lut_d_r  = r_lut_d[0];
    assign lut_d_g  = r_lut_d[1];
    assign lut_d_b  = r_lut_d[2];
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vp_bin_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vp_bin_lut_loader
// Description : Self-checking bench for vp_bin_lut_loader. Captures the LUT
//               write port into shadow memories and compares them against
//               expected LUT images built from the band rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vp_bin_lut_loader;

    logic       clk;
    logic       rst_n;
    logic       v_sync_in;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_lo_r, cfg_lo_g, cfg_lo_b;
    logic [7:0] cfg_hi_r, cfg_hi_g, cfg_hi_b;
`ifdef VP_BIN_INVERT_EN
    logic [2:0] cfg_inv;
`endif
    logic       lut_we;
    logic [7:0] lut_addr;
    logic [7:0] lut_d_r, lut_d_g, lut_d_b;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] shadow  [3][256];
    logic [7:0] exp_lut [3][256];
    int         wr_count;
    int         exp_addr;

    typedef struct {
        int lo_r; int hi_r;
        int lo_g; int hi_g;
        int lo_b; int hi_b;
        int n_r;  int n_g; int n_b;
    } vec_t;

    vp_bin_lut_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .v_sync_in (v_sync_in),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_lo_r  (cfg_lo_r),
        .cfg_lo_g  (cfg_lo_g),
        .cfg_lo_b  (cfg_lo_b),
        .cfg_hi_r  (cfg_hi_r),
        .cfg_hi_g  (cfg_hi_g),
        .cfg_hi_b  (cfg_hi_b),
`ifdef VP_BIN_INVERT_EN
        .cfg_inv   (cfg_inv),
`endif
        .lut_we    (lut_we),
        .lut_addr  (lut_addr),
        .lut_d_r   (lut_d_r),
        .lut_d_g   (lut_d_g),
        .lut_d_b   (lut_d_b),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor: the RAM image seen by the LUTs, plus address order
    always @(negedge clk) begin
        if (rst_n && lut_we) begin
            shadow[0][lut_addr] = lut_d_r;
            shadow[1][lut_addr] = lut_d_g;
            shadow[2][lut_addr] = lut_d_b;
            n_checks++;
            if (int'(lut_addr) != exp_addr) begin
                n_errors++;
                $display("FAIL write_addr_order: got %0d, expected %0d", lut_addr, exp_addr);
            end
            exp_addr++;
            wr_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected LUT image: background, then the inclusive band painted over it
    task automatic model_set(input int ch, input int lo, input int hi, input bit inv);
        for (int a = 0; a < 256; a++) exp_lut[ch][a] = inv ? 8'hFF : 8'h00;
        for (int a = lo; a <= hi; a++) exp_lut[ch][a] = inv ? 8'h00 : 8'hFF;
    endtask

    task automatic compare_luts(input string tag);
        for (int ch = 0; ch < 3; ch++) begin
            int bad;
            bad = -1;
            for (int a = 0; a < 256; a++) begin
                if (bad < 0 && shadow[ch][a] !== exp_lut[ch][a]) bad = a;
            end
            n_checks++;
            if (bad >= 0) begin
                n_errors++;
                $display("FAIL %s lut%0d addr %0d: got %0h, expected %0h",
                         tag, ch, bad, shadow[ch][bad], exp_lut[ch][bad]);
            end
        end
    endtask

    function automatic int count_ff(input int ch);
        int n;
        n = 0;
        for (int a = 0; a < 256; a++) if (shadow[ch][a] === 8'hFF) n++;
        return n;
    endfunction

    task automatic do_cfg(input int lr, input int hr, input int lg, input int hg,
                          input int lb, input int hb);
        check("cfg_ready before handshake", {31'd0, cfg_ready}, 32'd1);
        cfg_lo_r = 8'(lr); cfg_hi_r = 8'(hr);
        cfg_lo_g = 8'(lg); cfg_hi_g = 8'(hg);
        cfg_lo_b = 8'(lb); cfg_hi_b = 8'(hb);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("busy after handshake", {31'd0, busy}, 32'd1);
    endtask

    // Raise vsync and run one full load; disturb=1 adds a cfg pulse and a
    // second vsync edge in the middle of the write burst
    task automatic run_load(input string tag, input bit disturb);
        int  n;
        bit  seen;
        for (int ch = 0; ch < 3; ch++)
            for (int a = 0; a < 256; a++) shadow[ch][a] = 8'h5A;
        wr_count  = 0;
        exp_addr  = 0;
        v_sync_in = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            tick();
            n++;
            if (done) seen = 1'b1;
            if (n == 5) v_sync_in = 1'b0;
            if (disturb) begin
                if (n == 50) begin
                    cfg_lo_r = 8'd0; cfg_hi_r = 8'd255;
                    cfg_lo_g = 8'd0; cfg_hi_g = 8'd0;
                    cfg_lo_b = 8'd7; cfg_hi_b = 8'd9;
                    cfg_valid = 1'b1;
                end
                if (n == 52) check({tag, " cfg_ready during WRITE"}, {31'd0, cfg_ready}, 32'd0);
                if (n == 60) cfg_valid = 1'b0;
                if (n == 100) v_sync_in = 1'b1;
                if (n == 110) v_sync_in = 1'b0;
            end
        end
        v_sync_in = 1'b0;
        cfg_valid = 1'b0;
        check({tag, " cycles vsync->done"}, n, 32'd258);
        check({tag, " write count"}, wr_count, 32'd256);
        tick();
        check({tag, " done single pulse"}, {31'd0, done}, 32'd0);
        check({tag, " idle ready"}, {31'd0, cfg_ready}, 32'd1);
        compare_luts(tag);
    endtask

    initial begin
        vec_t vecs [4];
        bit   ok;
        int   n;

        vecs[0] = '{10, 20,   0, 255, 200, 100,  11, 256,   0};
        vecs[1] = '{ 5,  5, 255, 255,   0,   0,   1,   1,   1};
        vecs[2] = '{ 0, 127, 128, 255, 255,  0, 128, 128,   0};
        vecs[3] = '{100, 99, 64, 191,   1, 254,   0, 128, 254};

        rst_n = 1'b1; v_sync_in = 1'b0; cfg_valid = 1'b0;
        cfg_lo_r = 8'd0; cfg_lo_g = 8'd0; cfg_lo_b = 8'd0;
        cfg_hi_r = 8'd0; cfg_hi_g = 8'd0; cfg_hi_b = 8'd0;
`ifdef VP_BIN_INVERT_EN
        cfg_inv = 3'b000;
`endif
        wr_count = 0; exp_addr = 0;
        #2 rst_n = 1'b0;
        repeat (3) tick();

        // Reset values
        check("reset lut_we",    {31'd0, lut_we},    32'd0);
        check("reset lut_addr",  {24'd0, lut_addr},  32'd0);
        check("reset lut_d_r",   {24'd0, lut_d_r},   32'd0);
        check("reset lut_d_g",   {24'd0, lut_d_g},   32'd0);
        check("reset lut_d_b",   {24'd0, lut_d_b},   32'd0);
        check("reset done",      {31'd0, done},      32'd0);
        check("reset busy",      {31'd0, busy},      32'd0);
        check("reset cfg_ready", {31'd0, cfg_ready}, 32'd0);

        rst_n = 1'b1;
        tick(); tick();
        check("post-reset busy",      {31'd0, busy},      32'd1);
        check("post-reset cfg_ready", {31'd0, cfg_ready}, 32'd0);

        // Default load after reset: 0..127 off, 128..255 on
        for (int ch = 0; ch < 3; ch++) model_set(ch, 128, 255, 1'b0);
        run_load("init_load", 1'b0);
        for (int ch = 0; ch < 3; ch++) check("init_load ones", count_ff(ch), 32'd128);

        // Table-driven band configurations
        for (int i = 0; i < 4; i++) begin
            do_cfg(vecs[i].lo_r, vecs[i].hi_r, vecs[i].lo_g, vecs[i].hi_g,
                   vecs[i].lo_b, vecs[i].hi_b);
            model_set(0, vecs[i].lo_r, vecs[i].hi_r, 1'b0);
            model_set(1, vecs[i].lo_g, vecs[i].hi_g, 1'b0);
            model_set(2, vecs[i].lo_b, vecs[i].hi_b, 1'b0);
            run_load($sformatf("vec%0d", i), 1'b0);
            check($sformatf("vec%0d ones r", i), count_ff(0), vecs[i].n_r);
            check($sformatf("vec%0d ones g", i), count_ff(1), vecs[i].n_g);
            check($sformatf("vec%0d ones b", i), count_ff(2), vecs[i].n_b);
        end

        // Random bands against the model
        for (int i = 0; i < 4; i++) begin
            int b [6];
            for (int k = 0; k < 6; k++) b[k] = int'($urandom_range(0, 255));
            do_cfg(b[0], b[1], b[2], b[3], b[4], b[5]);
            model_set(0, b[0], b[1], 1'b0);
            model_set(1, b[2], b[3], 1'b0);
            model_set(2, b[4], b[5], 1'b0);
            run_load($sformatf("rand%0d", i), 1'b0);
        end

        // Config accepted with vsync already active: level must not start a load
        v_sync_in = 1'b1;
        tick(); tick();
        do_cfg(30, 40, 50, 60, 70, 80);
        wr_count = 0;
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (cfg_ready !== 1'b0 || lut_we !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        check("vs level: idle while held", {31'd0, ok}, 32'd1);
        check("vs level: no writes", wr_count, 32'd0);
        v_sync_in = 1'b0;
        tick(); tick();
        model_set(0, 30, 40, 1'b0);
        model_set(1, 50, 60, 1'b0);
        model_set(2, 70, 80, 1'b0);
        run_load("vs_level", 1'b0);

        // cfg pulse and extra vsync edge during WRITE are ignored
        do_cfg(3, 250, 16, 31, 128, 128);
        model_set(0, 3, 250, 1'b0);
        model_set(1, 16, 31, 1'b0);
        model_set(2, 128, 128, 1'b0);
        run_load("disturb", 1'b1);

        // Reset mid-burst aborts the write at once, defaults reload afterwards
        do_cfg(0, 255, 0, 255, 0, 255);
        wr_count = 0; exp_addr = 0;
        v_sync_in = 1'b1;
        n = 0;
        while (wr_count < 100 && n < 400) begin
            tick();
            n++;
        end
        v_sync_in = 1'b0;
        check("abort reached write 100", wr_count, 32'd100);
        rst_n = 1'b0;
        #1;
        check("abort lut_we async", {31'd0, lut_we}, 32'd0);
        check("abort done",         {31'd0, done},   32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("abort busy after release", {31'd0, busy}, 32'd1);
        for (int ch = 0; ch < 3; ch++) model_set(ch, 128, 255, 1'b0);
        run_load("reload", 1'b0);

`ifdef VP_BIN_INVERT_EN
        // Inverted red channel: single band point becomes the only zero
        cfg_inv = 3'b001;
        do_cfg(0, 0, 10, 20, 0, 255);
        cfg_inv = 3'b000;
        model_set(0, 0, 0, 1'b1);
        model_set(1, 10, 20, 1'b0);
        model_set(2, 0, 255, 1'b0);
        run_load("invert", 1'b0);
        check("invert ones r", count_ff(0), 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
